// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and width limits for serial_adder
//
// Purpose: holds the FSM state type and the legal WIDTH range used by the
// serial_adder top. Imported with "import serial_adder_pkg::*;".
// Ports: none (package).

package serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/full_adder_top.sv
// rtl/full_adder_top.sv - single-bit full adder built from two half adders
//
// Purpose: combinational bit slice in_1+in_2+cin.
// Ports:
//   in_1, in_2 : operand bits
//   cin        : carry in
//   sum        : sum bit
//   count      : carry out (the high bit of the 2-bit population count)

module full_adder_top (
  input  logic in_1,
  input  logic in_2,
  input  logic cin,
  output logic sum,
  output logic count
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_carry;

  half_adder u_ha0 (
    .a     (in_1),
    .b     (in_2),
    .sum   (ha0_sum),
    .carry (ha0_carry)
  );

  half_adder u_ha1 (
    .a     (ha0_sum),
    .b     (cin),
    .sum   (sum),
    .carry (ha1_carry)
  );

  // The two half-adder carries can never both be set, so OR is exact.
  assign count = ha0_carry | ha1_carry;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - single-bit half adder
//
// Purpose: combinational a+b producing sum and carry.
// Ports:
//   a, b   : input bits
//   sum    : a xor b
//   carry  : a and b

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder around one full adder cell
//
// Purpose: accepts two operands and a carry-in on start, adds one bit per
// clock LSB first through a single full_adder_top, then publishes the
// registered sum/cout with a one-cycle done pulse.
// Ports:
//   sys_clk : system clock, rising edge
//   sys_rst : asynchronous active-high reset
//   start   : request, sampled only while idle
//   in_a    : operand A, captured on acceptance
//   in_b    : operand B, captured on acceptance
//   cin     : carry-in, captured on acceptance
//   busy    : high while an addition is in progress
//   done    : one-cycle pulse when sum/cout update
//   sum     : registered result, held until next completion
//   cout    : registered carry-out, held until next completion

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder: WIDTH outside legal range");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             load;
  logic             last_bit;
  logic             fa_sum;
  logic             fa_count;
  logic [WIDTH-1:0] sum_sh_next;

  full_adder_top u_fa (
    .in_1  (a_sh[0]),
    .in_2  (b_sh[0]),
    .cin   (carry),
    .sum   (fa_sum),
    .count (fa_count)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at LSB.
  assign sum_sh_next = {fa_sum, sum_sh[WIDTH-1:1]};

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    load       = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) begin
          last_bit   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      if (load) begin
        a_sh   <= in_a;
        b_sh   <= in_b;
        carry  <= cin;
        cnt    <= '0;
        sum_sh <= '0;
      end else if (busy) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        sum_sh <= sum_sh_next;
        carry  <= fa_count;
        cnt    <= cnt + 1'b1;
        if (last_bit) begin
          sum  <= sum_sh_next;
          cout <= fa_count;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
